// File: rtl/sio_uart_bridge.sv
// Register-mapped 8N1 UART between the HPS extension bus and the Atari SIO data lines.
// Separate TX/RX FIFOs feed bit-timing FSMs whose bit period is (div+1)*PRESCALE clocks.
module sio_uart_bridge #(
  parameter int FIFO_AW   = 4,
  parameter int PRESCALE  = 16,
  parameter int DIV_RESET = 185
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [4:0]  uart_addr,
  input  logic        uart_enable,
  input  logic        uart_wr,
  input  logic [7:0]  uart_data_write,
  output logic [15:0] uart_data_read,
  input  logic        sio_rx,
  output logic        sio_tx,
  input  logic        sio_cmd_n
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(256 * PRESCALE + 1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [CW-1:0]      CW_ONE   = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  function automatic logic [CW-1:0] bit_len(input logic [7:0] d);
    return CW'((32'(d) + 32'd1) * 32'(PRESCALE));
  endfunction

  // Bus handshake: uart_enable and uart_wr are one-cycle strobes qualified by uart_addr.
  // There is no backpressure; every strobe is taken in the cycle it is seen, and read data
  // is registered into uart_data_read on the following edge, held until the next read.
  logic wr_data, wr_div, rd_pop, rd_err;
  assign wr_data = uart_wr && (uart_addr == 5'd0);
  assign wr_div  = uart_wr && (uart_addr == 5'd4);
  assign rd_pop  = uart_enable && (uart_addr == 5'd2);
  assign rd_err  = uart_enable && (uart_addr == 5'd5);

  logic [7:0] div_q;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset)       div_q <= 8'(DIV_RESET);
    else if (wr_div) div_q <= uart_data_write;

  logic rx_s1, rx_s2, rx_prev, cmd_s1, cmd_s2;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1; cmd_s1 <= 1'b1; cmd_s2 <= 1'b1;
    end else begin
      rx_s1 <= sio_rx; rx_s2 <= rx_s1; rx_prev <= rx_s2; cmd_s1 <= sio_cmd_n; cmd_s2 <= cmd_s1;
    end

  // TX FIFO
  logic [7:0]         tx_mem [DEPTH];
  logic [FIFO_AW-1:0] tx_wp, tx_rp;
  logic [FIFO_AW:0]   tx_cnt;
  logic tx_full, tx_empty, tx_push, tx_pop, tx_drop;
  assign tx_full  = (tx_cnt == CNT_FULL);
  assign tx_empty = (tx_cnt == '0);
  assign tx_push  = wr_data && !tx_full;
  assign tx_drop  = wr_data && tx_full;

  always_ff @(posedge clk_sys)
    if (tx_push) tx_mem[tx_wp] <= uart_data_write;

  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
        2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
        default: ;
      endcase
    end

  // RX FIFO entries are {ferr, byte}; a pop frees room for a same-cycle push
  logic [8:0]         rx_mem [DEPTH];
  logic [FIFO_AW-1:0] rx_wp, rx_rp;
  logic [FIFO_AW:0]   rx_cnt;
  logic rx_full, rx_empty, rx_push, rx_pop, rx_wr, rx_drop, rx_ferr;
  logic [7:0] rx_sh;
  assign rx_full  = (rx_cnt == CNT_FULL);
  assign rx_empty = (rx_cnt == '0);
  assign rx_pop   = rd_pop && !rx_empty;
  assign rx_wr    = rx_push && (!rx_full || rx_pop);
  assign rx_drop  = rx_push && rx_full && !rx_pop;

  always_ff @(posedge clk_sys)
    if (rx_wr) rx_mem[rx_wp] <= {rx_ferr, rx_sh};

  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      if (rx_wr)  rx_wp <= rx_wp + PTR_ONE;
      if (rx_pop) rx_rp <= rx_rp + PTR_ONE;
      case ({rx_wr, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
        2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
        default: ;
      endcase
    end

  // TX FSM; the line is bit 0 of a 10-bit frame register so sio_tx comes straight from a flop
  state_t         tx_state, tx_state_nx;
  logic [9:0]     tx_frame;
  logic [7:0]     tx_div_q;
  logic [CW-1:0]  tx_timer, tx_len;
  logic [2:0]     tx_idx;
  logic           tx_tick, tx_load, tx_busy;
  assign tx_len  = bit_len(tx_div_q);
  assign tx_tick = (tx_timer == tx_len - CW_ONE);
  assign sio_tx  = tx_frame[0];

  always_ff @(posedge clk_sys or posedge reset)
    if (reset) tx_state <= S_IDLE;
    else       tx_state <= tx_state_nx;

  always_comb begin
    tx_state_nx = tx_state;
    case (tx_state)
      S_IDLE:  if (!tx_empty) tx_state_nx = S_START;
      S_START: if (tx_tick) tx_state_nx = S_DATA;
      S_DATA:  if (tx_tick && tx_idx == 3'd7) tx_state_nx = S_STOP;
      S_STOP:  if (tx_tick) tx_state_nx = tx_empty ? S_IDLE : S_START;
      default: tx_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    tx_load = (tx_state_nx == S_START) && (tx_state != S_START);
    tx_busy = (tx_state != S_IDLE);
    tx_pop  = tx_load;
  end

  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      tx_frame <= '1; tx_div_q <= '0; tx_timer <= '0; tx_idx <= '0;
    end else if (tx_load) begin
      tx_frame <= {1'b1, tx_mem[tx_rp], 1'b0};
      tx_div_q <= div_q;
      tx_timer <= '0;
      tx_idx   <= '0;
    end else if (tx_busy) begin
      if (tx_tick) begin
        tx_frame <= {1'b1, tx_frame[9:1]};
        tx_timer <= '0;
        if (tx_state == S_DATA) tx_idx <= tx_idx + 3'd1;
      end else begin
        tx_timer <= tx_timer + CW_ONE;
      end
    end

  // RX FSM; START lasts half a bit so later samples land at bit centres
  state_t         rx_state, rx_state_nx;
  logic [7:0]     rx_div_q;
  logic [CW-1:0]  rx_timer, rx_len, rx_half;
  logic [2:0]     rx_idx;
  logic           rx_tick, rx_half_tick, rx_fall;
  assign rx_len       = bit_len(rx_div_q);
  assign rx_half      = rx_len >> 1;
  assign rx_tick      = (rx_timer == rx_len - CW_ONE);
  assign rx_half_tick = (rx_timer == rx_half - CW_ONE);
  assign rx_fall      = rx_prev && !rx_s2;

  always_ff @(posedge clk_sys or posedge reset)
    if (reset) rx_state <= S_IDLE;
    else       rx_state <= rx_state_nx;

  always_comb begin
    rx_state_nx = rx_state;
    case (rx_state)
      S_IDLE:  if (rx_fall) rx_state_nx = S_START;
      S_START: if (rx_half_tick) rx_state_nx = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick && rx_idx == 3'd7) rx_state_nx = S_STOP;
      S_STOP:  if (rx_tick) rx_state_nx = S_IDLE;
      default: rx_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rx_push = (rx_state == S_STOP) && rx_tick;
    rx_ferr = !rx_s2;
  end

  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      rx_div_q <= '0; rx_timer <= '0; rx_idx <= '0; rx_sh <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          rx_timer <= '0;
          rx_idx   <= '0;
          if (rx_fall) rx_div_q <= div_q;
        end
        S_START: rx_timer <= rx_half_tick ? '0 : rx_timer + CW_ONE;
        S_DATA: begin
          if (rx_tick) begin
            rx_timer <= '0;
            rx_sh    <= {rx_s2, rx_sh[7:1]};
            rx_idx   <= rx_idx + 3'd1;
          end else begin
            rx_timer <= rx_timer + CW_ONE;
          end
        end
        S_STOP:  rx_timer <= rx_tick ? '0 : rx_timer + CW_ONE;
        default: rx_timer <= '0;
      endcase
    end

  // Sticky errors: a set in the same cycle as the clearing read wins
  logic err_rx_overrun, err_framing, err_tx_overflow;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      err_rx_overrun <= 1'b0; err_framing <= 1'b0; err_tx_overflow <= 1'b0;
    end else begin
      err_rx_overrun  <= (err_rx_overrun  && !rd_err) || rx_drop;
      err_framing     <= (err_framing     && !rd_err) || (rx_push && rx_ferr);
      err_tx_overflow <= (err_tx_overflow && !rd_err) || tx_drop;
    end

  logic [15:0] rd_data;
  always_comb begin
    rd_data = '0;
    case (uart_addr)
      5'd1: begin
        rd_data[0] = tx_full;
        rd_data[1] = tx_empty;
        rd_data[2] = tx_busy;
        rd_data[8 +: FIFO_AW + 1] = tx_cnt;
      end
      5'd2: if (!rx_empty) rd_data[9:0] = {rx_mem[rx_rp][8], 1'b1, rx_mem[rx_rp][7:0]};
      5'd3: begin
        rd_data[0] = rx_empty;
        rd_data[1] = rx_full;
        rd_data[2] = !cmd_s2;
        rd_data[8 +: FIFO_AW + 1] = rx_cnt;
      end
      5'd4: rd_data[7:0] = div_q;
      5'd5: rd_data[2:0] = {err_tx_overflow, err_framing, err_rx_overrun};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset)
    if (reset)            uart_data_read <= '0;
    else if (uart_enable) uart_data_read <= rd_data;

endmodule

// File: tb/tb_sio_uart_bridge.sv
// Randomised bench for sio_uart_bridge: bus driver tasks, a serial line model on both
// directions, and a scoreboard of expected TX frames and RX bytes.
module tb_sio_uart_bridge;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic [4:0]  uart_addr;
  logic        uart_enable, uart_wr;
  logic [7:0]  uart_data_write;
  logic [15:0] uart_data_read;
  logic        sio_rx, sio_tx, sio_cmd_n;

  int tests_run = 0;
  int tests_failed = 0;

  sio_uart_bridge #(.FIFO_AW(4), .PRESCALE(16), .DIV_RESET(185)) dut (
    .clk_sys(clk_sys), .reset(reset), .uart_addr(uart_addr), .uart_enable(uart_enable),
    .uart_wr(uart_wr), .uart_data_write(uart_data_write), .uart_data_read(uart_data_read),
    .sio_rx(sio_rx), .sio_tx(sio_tx), .sio_cmd_n(sio_cmd_n)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  // reference model state
  logic [9:0] exp_q[$];      // expected TX frames, bit i = line level during bit i
  int         exp_len_q[$];  // bit period of each expected TX frame
  logic [8:0] rx_q[$];       // expected RX FIFO contents {ferr, byte}
  logic [2:0] err_model = 3'b000;
  logic [7:0] cur_div = 8'd185;
  logic       mon_en = 1'b1;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int bitcyc(input logic [7:0] d);
    return (int'(d) + 1) * 16;
  endfunction

  // driver tasks
  task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    uart_addr = a; uart_data_write = d; uart_wr = 1'b1;
    @(negedge clk_sys);
    uart_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [15:0] d);
    @(negedge clk_sys);
    uart_addr = a; uart_enable = 1'b1;
    @(negedge clk_sys);
    uart_enable = 1'b0;
    d = uart_data_read;
  endtask

  task automatic set_div(input logic [7:0] d);
    bus_write(5'd4, d);
    cur_div = d;
  endtask

  task automatic tx_byte(input logic [7:0] b);
    exp_q.push_back({1'b1, b, 1'b0});
    exp_len_q.push_back(bitcyc(cur_div));
    bus_write(5'd0, b);
  endtask

  task automatic read_check(input logic [4:0] a, input string tag);
    logic [15:0] got, exp;
    logic [8:0]  ent;
    int          n;
    exp = 16'h0000;
    n = rx_q.size();
    case (a)
      5'd2: if (n > 0) begin
        ent = rx_q.pop_front();
        exp = {6'b0, ent[8], 1'b1, ent[7:0]};
      end
      5'd3: exp = {3'b0, 5'(n), 5'b0, !sio_cmd_n, n == 16, n == 0};
      5'd4: exp = {8'h00, cur_div};
      5'd5: begin
        exp = {13'b0, err_model};
        err_model = 3'b000;
      end
      default: exp = 16'h0000;
    endcase
    bus_read(a, got);
    check(tag, got, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input int len, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      sio_rx = f[i];
      repeat (len) @(negedge clk_sys);
    end
    sio_rx = 1'b1;
    if (rx_q.size() < 16) rx_q.push_back({!stop_bit, b});
    else err_model[0] = 1'b1;
    if (!stop_bit) err_model[1] = 1'b1;
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic wait_tx_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk_sys);
      n++;
    end
    check("tx_drain", 16'(exp_q.size()), 16'd0);
    repeat (8) @(negedge clk_sys);
  endtask

  // TX line monitor: samples each bit at its centre and scores the frame
  initial begin : tx_monitor
    logic       prev;
    logic [9:0] got;
    int         len;
    prev = 1'b1;
    forever begin
      @(negedge clk_sys);
      if (mon_en && prev && !sio_tx) begin
        check("tx_exp_avail", 16'(exp_len_q.size() != 0), 16'd1);
        len = (exp_len_q.size() != 0) ? exp_len_q.pop_front() : 16;
        repeat (len / 2) @(negedge clk_sys);
        for (int i = 0; i < 10; i++) begin
          got[i] = sio_tx;
          if (i < 9) repeat (len) @(negedge clk_sys);
        end
        if (exp_q.size() != 0) check("tx_frame", {6'b0, got}, {6'b0, exp_q.pop_front()});
        else check("tx_frame_unexpected", {6'b0, got}, 16'h0000);
      end
      prev = sio_tx;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] rd;
    logic [7:0]  b, a0, a1;
    int          k, n, lows;
    reset = 1'b1; uart_addr = '0; uart_enable = 1'b0; uart_wr = 1'b0;
    uart_data_write = '0; sio_rx = 1'b1; sio_cmd_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("rst_data_read", uart_data_read, 16'h0000);
    check("rst_sio_tx", {15'b0, sio_tx}, 16'h0001);
    reset = 1'b0;
    read_check(5'd4, "rst_div");
    bus_read(5'd1, rd);
    check("rst_tx_status", rd, 16'h0002);
    read_check(5'd3, "rst_rx_status");
    read_check(5'd5, "rst_errors");

    // single TX frame at BITCYC=16
    set_div(8'd0);
    tx_byte(8'hA5);
    k = 0;
    while (sio_tx !== 1'b0 && k < 4) begin
      @(negedge clk_sys);
      k++;
    end
    check("tx_start_latency_ok", 16'(k <= 2), 16'd1);
    bus_read(5'd1, rd);
    check("tx_status_busy", rd, 16'h0006);
    wait_tx_drain(400);

    // randomised TX bursts
    for (int r = 0; r < 2; r++) begin
      set_div(8'($urandom_range(0, 3)));
      n = $urandom_range(3, 8);
      for (int i = 0; i < n; i++) tx_byte(8'($urandom));
      wait_tx_drain(9 * 640 + 100);
    end

    // RX basic frame, empty pop, cmd line
    set_div(8'd0);
    send_rx(8'h3C, 16, 1'b1);
    read_check(5'd3, "rx_status_one");
    read_check(5'd2, "rx_pop_3c");
    read_check(5'd2, "rx_pop_empty");
    sio_cmd_n = 1'b0;
    repeat (4) @(negedge clk_sys);
    read_check(5'd3, "rx_cmd_active");
    sio_cmd_n = 1'b1;
    repeat (4) @(negedge clk_sys);

    // framing error
    send_rx(8'h55, 16, 1'b0);
    read_check(5'd2, "rx_pop_ferr");
    read_check(5'd5, "err_framing");
    read_check(5'd5, "err_cleared");

    // randomised RX frames with varying divisor and occasional bad stop bit
    for (int r = 0; r < 6; r++) begin
      set_div(8'($urandom_range(0, 3)));
      send_rx(8'($urandom), bitcyc(cur_div), ($urandom_range(0, 3) != 0));
      if (r % 3 == 2) begin
        read_check(5'd3, "rx_rand_status");
        for (int i = 0; i < 4; i++) read_check(5'd2, "rx_rand_pop");
        read_check(5'd5, "rx_rand_err");
      end
    end

    // RX overrun: 17 frames without reads
    set_div(8'd0);
    for (int i = 0; i < 17; i++) send_rx(8'($urandom), 16, 1'b1);
    read_check(5'd3, "rx_full_status");
    read_check(5'd5, "err_overrun");
    for (int i = 0; i < 16; i++) read_check(5'd2, "rx_full_pop");
    read_check(5'd3, "rx_drained_status");

    // TX overflow behind a slow frame, then the rest at BITCYC=16
    set_div(8'd100);
    tx_byte(8'($urandom));
    set_div(8'd0);
    cur_div = 8'd100;
    bus_write(5'd4, 8'd100);
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (i < 16) begin
        exp_q.push_back({1'b1, b, 1'b0});
        exp_len_q.push_back(16);
        bus_write(5'd0, b);
      end else begin
        bus_write(5'd0, b);
        err_model[2] = 1'b1;
      end
    end
    bus_read(5'd1, rd);
    check("tx_full_status", rd, 16'h1005);
    read_check(5'd5, "err_tx_overflow");
    set_div(8'd0);
    wait_tx_drain(16160 + 16 * 160 + 400);

    // divisor change during an RX frame applies from the next frame
    a0 = 8'($urandom);
    a1 = 8'($urandom);
    fork
      send_rx(a0, 16, 1'b1);
      begin
        repeat (50) @(negedge clk_sys);
        bus_write(5'd4, 8'd10);
      end
    join
    cur_div = 8'd10;
    read_check(5'd2, "rx_old_rate");
    send_rx(a1, 176, 1'b1);
    read_check(5'd2, "rx_new_rate");
    read_check(5'd4, "div_readback");
    sio_rx = 1'b0;
    repeat (53) @(negedge clk_sys);
    sio_rx = 1'b1;
    repeat (3 * 176) @(negedge clk_sys);
    read_check(5'd3, "glitch_no_push");
    read_check(5'd5, "glitch_no_error");

    // asynchronous reset in the middle of a TX frame
    set_div(8'd3);
    read_check(5'd4, "div_before_reset");
    mon_en = 1'b0;
    bus_write(5'd0, 8'h00);
    repeat (100) @(negedge clk_sys);
    check("tx_low_before_reset", {15'b0, sio_tx}, 16'h0000);
    #2 reset = 1'b1;
    #1;
    check("async_rst_sio_tx", {15'b0, sio_tx}, 16'h0001);
    check("async_rst_data_read", uart_data_read, 16'h0000);
    @(negedge clk_sys);
    reset = 1'b0;
    cur_div = 8'd185;
    rx_q.delete();
    err_model = 3'b000;
    repeat (2) @(negedge clk_sys);
    mon_en = 1'b1;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_sys);
      if (sio_tx !== 1'b1) lows++;
    end
    check("post_reset_line_idle", 16'(lows), 16'd0);
    bus_read(5'd1, rd);
    check("post_reset_tx_status", rd, 16'h0002);
    read_check(5'd4, "post_reset_div");
    read_check(5'd3, "post_reset_rx_status");

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
